// File: rtl/mdu_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: op codes, FSM states
// and the divider iteration count.
package mdu_pkg;

  localparam logic [2:0] MDU_MULT  = 3'd0;
  localparam logic [2:0] MDU_MULTU = 3'd1;
  localparam logic [2:0] MDU_DIV   = 3'd2;
  localparam logic [2:0] MDU_DIVU  = 3'd3;
  localparam logic [2:0] MDU_MTHI  = 3'd4;
  localparam logic [2:0] MDU_MTLO  = 3'd5;

  localparam int DIV_ITER = 32;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_FIX
  } mdu_state_t;

endpackage

// File: rtl/mdu_div_core.sv
// Restoring radix-2 divider on unsigned magnitudes: load latches the operands,
// each step retires one quotient bit (MSB first).
module mdu_div_core
  import mdu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  output logic [DATA_W-1:0] quotient,
  output logic [DATA_W-1:0] remainder
);

  logic [DATA_W-1:0] quo_q;
  logic [DATA_W-1:0] rem_q;
  logic [DATA_W-1:0] dvs_q;
  logic [DATA_W:0]   shifted;
  logic              fits;

  // Partial remainder is always below the divisor, so the subtraction result
  // fits in DATA_W bits even though the shifted value needs one extra bit.
  assign shifted = {rem_q, quo_q[DATA_W-1]};
  assign fits    = shifted >= {1'b0, dvs_q};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      quo_q <= '0;
      rem_q <= '0;
      dvs_q <= '0;
    end else if (load) begin
      quo_q <= dividend;
      rem_q <= '0;
      dvs_q <= divisor;
    end else if (step) begin
      quo_q <= {quo_q[DATA_W-2:0], fits};
      rem_q <= fits ? (shifted[DATA_W-1:0] - dvs_q) : shifted[DATA_W-1:0];
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/mdu_hilo.sv
// EX-stage multiply/divide unit owning HI/LO: iterative MULT/MULTU/DIV/DIVU
// with a busy stall flag, plus single-cycle MTHI/MTLO.
module mdu_hilo
  import mdu_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int MULT_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  localparam logic [4:0] MUL_LAST = 5'(MULT_CYCLES - 1);
  localparam logic [4:0] DIV_LAST = 5'(DIV_ITER - 1);

  function automatic logic [DATA_W-1:0] f_cond_neg(input logic [DATA_W-1:0] x,
                                                   input logic neg);
    return neg ? (~x + 1'b1) : x;
  endfunction

  mdu_state_t state, state_nxt;
  logic [4:0] cnt, cnt_nxt;
  logic       busy_nxt, done_nxt;
  logic       mul_ld, mul_wr, div_ld, div_step, div_wr, mthi_wr, mtlo_wr;

  logic [2*DATA_W-1:0] a_ext, b_ext, prod, prod_q;
  logic [DATA_W-1:0]   mag_a, mag_b, a_keep, quo, rem;
  logic                q_neg, r_neg, dbz;
  logic                is_mult, is_div;

  assign is_mult = (op == MDU_MULT);
  assign is_div  = (op == MDU_DIV);
  assign a_ext   = is_mult ? {{DATA_W{a[DATA_W-1]}}, a} : {{DATA_W{1'b0}}, a};
  assign b_ext   = is_mult ? {{DATA_W{b[DATA_W-1]}}, b} : {{DATA_W{1'b0}}, b};
  assign prod    = a_ext * b_ext;
  assign mag_a   = f_cond_neg(a, is_div & a[DATA_W-1]);
  assign mag_b   = f_cond_neg(b, is_div & b[DATA_W-1]);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    busy_nxt  = busy;
    done_nxt  = 1'b0;
    mul_ld    = 1'b0;
    mul_wr    = 1'b0;
    div_ld    = 1'b0;
    div_step  = 1'b0;
    div_wr    = 1'b0;
    mthi_wr   = 1'b0;
    mtlo_wr   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          case (op)
            MDU_MULT, MDU_MULTU: begin
              state_nxt = ST_MUL;
              busy_nxt  = 1'b1;
              cnt_nxt   = MUL_LAST;
              mul_ld    = 1'b1;
            end
            MDU_DIV, MDU_DIVU: begin
              state_nxt = ST_DIV;
              busy_nxt  = 1'b1;
              cnt_nxt   = DIV_LAST;
              div_ld    = 1'b1;
            end
            MDU_MTHI: mthi_wr = 1'b1;
            MDU_MTLO: mtlo_wr = 1'b1;
            default: ;
          endcase
        end
      end
      ST_MUL: begin
        if (cnt == '0) begin
          state_nxt = ST_IDLE;
          busy_nxt  = 1'b0;
          done_nxt  = 1'b1;
          mul_wr    = 1'b1;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      ST_DIV: begin
        div_step = 1'b1;
        if (cnt == '0) state_nxt = ST_FIX;
        else           cnt_nxt   = cnt - 1'b1;
      end
      ST_FIX: begin
        state_nxt = ST_IDLE;
        busy_nxt  = 1'b0;
        done_nxt  = 1'b1;
        div_wr    = 1'b1;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      busy  <= busy_nxt;
      done  <= done_nxt;
    end
  end

  mdu_div_core #(.DATA_W(DATA_W)) u_div (
    .clk      (clk),
    .rst      (rst),
    .load     (div_ld),
    .step     (div_step),
    .dividend (mag_a),
    .divisor  (mag_b),
    .quotient (quo),
    .remainder(rem)
  );

  // Divide-by-zero bypasses sign fix-up: LO is all ones, HI is the raw dividend.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prod_q <= '0;
      a_keep <= '0;
      q_neg  <= 1'b0;
      r_neg  <= 1'b0;
      dbz    <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      if (mul_ld) prod_q <= prod;
      if (div_ld) begin
        a_keep <= a;
        q_neg  <= is_div & (a[DATA_W-1] ^ b[DATA_W-1]);
        r_neg  <= is_div & a[DATA_W-1];
        dbz    <= (b == '0);
      end
      if (mul_wr) begin
        hi <= prod_q[2*DATA_W-1:DATA_W];
        lo <= prod_q[DATA_W-1:0];
      end else if (div_wr) begin
        hi <= dbz ? a_keep : f_cond_neg(rem, r_neg);
        lo <= dbz ? '1     : f_cond_neg(quo, q_neg);
      end else if (mthi_wr) begin
        hi <= a;
      end else if (mtlo_wr) begin
        lo <= a;
      end
    end
  end

endmodule

// File: tb/tb_mdu_hilo.sv
// Self-checking bench for mdu_hilo: directed table, MTHI/MTLO, mid-busy start,
// async reset abort, and randomized ops against an arithmetic model.
module tb_mdu_hilo;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, start2;
  logic [2:0]  op, op2;
  logic [31:0] a, b, a2, b2;
  logic        busy, done, busy2, done2;
  logic [31:0] hi, lo, hi2, lo2;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mdu_hilo #(.DATA_W(32), .MULT_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .hi(hi), .lo(lo));

  mdu_hilo #(.DATA_W(32), .MULT_CYCLES(16)) dut16 (
    .clk(clk), .rst(rst), .start(start2), .op(op2), .a(a2), .b(b2),
    .busy(busy2), .done(done2), .hi(hi2), .lo(lo2));

  // The hazard unit never requests while busy; the main instance relies on it.
  always @(posedge clk)
    if (!rst) assert (!(busy && start)) else $error("start issued while busy");

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a, b, hi, lo;
    int          lat;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Issue one request on the main instance; count busy cycles and done pulses.
  task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                        output int lat, output int nd);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0; a = $urandom; b = $urandom;
    lat = 0; nd = 0;
    while (busy && lat < 100) begin
      lat++;
      nd += int'(done);
      @(negedge clk);
    end
    nd += int'(done);
    @(negedge clk);
    nd += int'(done);
  endtask

  task automatic model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                       inout logic [31:0] h, inout logic [31:0] l,
                       output int lat, output int nd);
    longint sx, sy, q, r;
    logic [63:0] p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    lat = 0; nd = 0;
    case (o)
      MDU_MULT:  begin q = sx * sy; {h, l} = q; lat = 4; nd = 1; end
      MDU_MULTU: begin p = {32'd0, x} * {32'd0, y}; {h, l} = p; lat = 4; nd = 1; end
      MDU_DIV, MDU_DIVU: begin
        lat = 33; nd = 1;
        if (y == 32'd0) begin
          l = 32'hFFFF_FFFF; h = x;
        end else if (o == MDU_DIV) begin
          q = sx / sy; r = sx % sy;
          l = q[31:0]; h = r[31:0];
        end else begin
          l = x / y; h = x % y;
        end
      end
      MDU_MTHI: h = x;
      MDU_MTLO: l = x;
      default: ;
    endcase
  endtask

  initial begin
    vec_t        vecs[8];
    int          lat, nd, elat, end_, cnt_b, cnt_d;
    logic [31:0] m_hi, m_lo, ra, rb;
    logic [2:0]  ro;

    vecs[0] = '{MDU_MULT,  32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFE, 4};
    vecs[1] = '{MDU_MULTU, 32'hFFFF_FFFF, 32'd2,         32'h0000_0001, 32'hFFFF_FFFE, 4};
    vecs[2] = '{MDU_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 33};
    vecs[3] = '{MDU_DIVU,  32'd100,       32'd7,         32'd2,         32'd14,        33};
    vecs[4] = '{MDU_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 33};
    vecs[5] = '{MDU_DIVU,  32'h0000_1234, 32'd0,         32'h0000_1234, 32'hFFFF_FFFF, 33};
    vecs[6] = '{MDU_DIV,   32'hFFFF_FFF0, 32'd0,         32'hFFFF_FFF0, 32'hFFFF_FFFF, 33};
    vecs[7] = '{MDU_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 33};

    rst = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
    start2 = 1'b0; op2 = '0; a2 = '0; b2 = '0;
    repeat (2) @(negedge clk);
    chk("reset hi", 64'(hi), 64'd0);
    chk("reset lo", 64'(lo), 64'd0);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset done", 64'(done), 64'd0);
    rst = 1'b0;

    foreach (vecs[i]) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat, nd);
      chk($sformatf("vec%0d hi", i), 64'(hi), 64'(vecs[i].hi));
      chk($sformatf("vec%0d lo", i), 64'(lo), 64'(vecs[i].lo));
      chk($sformatf("vec%0d busy cycles", i), 64'(lat), 64'(vecs[i].lat));
      chk($sformatf("vec%0d done pulses", i), 64'(nd), 64'd1);
    end

    // MTHI then MTLO on consecutive edges.
    @(negedge clk);
    start = 1'b1; op = MDU_MTHI; a = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("mthi hi", 64'(hi), 64'hDEAD_BEEF);
    chk("mthi lo kept", 64'(lo), 64'hFFFF_FFFD);
    chk("mthi busy", 64'(busy), 64'd0);
    chk("mthi done", 64'(done), 64'd0);
    op = MDU_MTLO; a = 32'h0BAD_F00D;
    @(negedge clk);
    chk("mtlo lo", 64'(lo), 64'h0BAD_F00D);
    chk("mtlo hi kept", 64'(hi), 64'hDEAD_BEEF);
    chk("mtlo busy", 64'(busy), 64'd0);
    chk("mtlo done", 64'(done), 64'd0);
    op = 3'd6; a = 32'h1111_1111;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("reserved hi", 64'(hi), 64'hDEAD_BEEF);
    chk("reserved lo", 64'(lo), 64'h0BAD_F00D);
    chk("reserved busy", 64'(busy), 64'd0);

    // DIVU requested on cycle 10 of a 16-cycle MULT must be dropped.
    start2 = 1'b1; op2 = MDU_MULT; a2 = 32'h1234_5678; b2 = 32'hFFFF_FFFD;
    @(negedge clk);
    start2 = 1'b0;
    repeat (9) @(negedge clk);
    start2 = 1'b1; op2 = MDU_DIVU; a2 = 32'd100; b2 = 32'd7;
    @(negedge clk);
    start2 = 1'b0;
    lat = 10; cnt_d = 0;
    while (busy2 && lat < 100) begin
      lat++;
      cnt_d += int'(done2);
      @(negedge clk);
    end
    chk("midbusy busy cycles", 64'(lat), 64'd16);
    chk("midbusy done", 64'(done2), 64'd1);
    chk("midbusy early done", 64'(cnt_d), 64'd0);
    repeat (3) @(negedge clk);
    chk("midbusy no restart", 64'(busy2), 64'd0);
    chk("midbusy hi", 64'(hi2), 64'hFFFF_FFFF);
    chk("midbusy lo", 64'(lo2), 64'hC962_FC98);

    // Async reset in cycle 15 of a DIV.
    start = 1'b1; op = MDU_DIV; a = 32'hFFFF_FFF9; b = 32'd2;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    chk("abort busy before", 64'(busy), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("abort hi", 64'(hi), 64'd0);
    chk("abort lo", 64'(lo), 64'd0);
    chk("abort busy", 64'(busy), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    cnt_b = 0; cnt_d = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      cnt_b += int'(busy);
      cnt_d += int'(done);
    end
    chk("abort later busy", 64'(cnt_b), 64'd0);
    chk("abort later done", 64'(cnt_d), 64'd0);
    chk("abort later lo", 64'(lo), 64'd0);
    run_op(MDU_MULTU, 32'd3, 32'd5, lat, nd);
    chk("post-reset lo", 64'(lo), 64'd15);
    chk("post-reset hi", 64'(hi), 64'd0);
    chk("post-reset busy cycles", 64'(lat), 64'd4);

    m_hi = 32'd0; m_lo = 32'd15;
    for (int i = 0; i < 40; i++) begin
      ro = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 5))
        0: rb = 32'd0;
        1: begin ra = 32'($urandom_range(0, 200)); rb = 32'($urandom_range(1, 20)); end
        2: ra = 32'h8000_0000;
        default: ;
      endcase
      model(ro, ra, rb, m_hi, m_lo, elat, end_);
      run_op(ro, ra, rb, lat, nd);
      chk($sformatf("rand%0d op%0d hi", i, ro), 64'(hi), 64'(m_hi));
      chk($sformatf("rand%0d op%0d lo", i, ro), 64'(lo), 64'(m_lo));
      chk($sformatf("rand%0d op%0d busy cycles", i, ro), 64'(lat), 64'(elat));
      chk($sformatf("rand%0d op%0d done pulses", i, ro), 64'(nd), 64'(end_));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mdu_hilo.md
Name: mdu_hilo

Overview:
- Multi-cycle multiply/divide unit with HI/LO registers in the EX stage.
- Consumes the forwarded rs/rt operands produced by the EX-stage operand forwarding mux.
- Executes MULT/MULTU/DIV/DIVU iteratively, and MTHI/MTLO in a single cycle.
- Asserts busy so the hazard logic stalls IF/ID/EX while a result is pending.

Parameters:
- DATA_W, 32, operand/HI/LO width; only 32 is supported.
- MULT_CYCLES, 4, cycles busy is held for a multiply (legal range 1..16).

Ports:
- clk  input  1  single clock, rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  operation request, qualified by the op field
- op  input  3  operation code: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; 6 and 7 reserved (no-op)
- a  input  DATA_W  forwarded rs operand
- b  input  DATA_W  forwarded rt operand
- busy  output  1  multi-cycle operation in flight
- done  output  1  one-cycle pulse when HI/LO are updated by a mult/div
- hi  output  DATA_W  HI register
- lo  output  DATA_W  LO register

Behaviour:
- Reset (async, any time):
  - state goes to IDLE; hi, lo, busy, done and all counters/shadow registers go to 0.
  - Reset during MUL or DIV aborts the operation; no HI/LO update follows.
- States: IDLE, MUL, DIV, FIX.
- Acceptance: start is accepted only in IDLE, on the clock edge. When busy=1, start is ignored and HI/LO are untouched. The hazard unit guarantees this never happens; the bench asserts it.
- MTHI/MTLO (accepted in IDLE):
  - hi (or lo) <= a on that edge; the other register is unchanged.
  - busy stays 0 and done stays 0.
- MULT/MULTU:
  - On the accepting edge, the 64-bit signed (MULT) or unsigned (MULTU) product is latched into a shadow register; state goes to MUL and busy goes to 1.
  - The counter runs for MULT_CYCLES cycles. On the final edge, {hi,lo} <= product, done goes to 1 for one cycle, busy goes to 0, and state returns to IDLE.
  - busy is high for exactly MULT_CYCLES cycles.
- DIV/DIVU:
  - On the accepting edge, magnitudes are latched: |a| and |b| for DIV, raw a and b for DIVU. The quotient sign (a[31]^b[31]) and remainder sign (a[31]) are also latched for DIV. State goes to DIV and busy goes to 1.
  - DIV performs 32 restoring radix-2 iterations, one per cycle, then moves to FIX.
  - FIX (1 cycle): apply the sign corrections; hi <= remainder, lo <= quotient; done pulses; return to IDLE.
  - busy is high for exactly 33 cycles.
- Divide by zero (b==0, signed or unsigned):
  - Full latency still applies.
  - Result: lo = 0xFFFFFFFF, hi = a (original value, unsigned interpretation of the bits).
- Signed overflow 0x80000000 / 0xFFFFFFFF: lo = 0x80000000, hi = 0. This falls out of the magnitude path and needs no special case.
- Remainder sign follows the dividend; quotient truncates toward zero.
- hi/lo hold their value in all other cycles. Readers (MFHI/MFLO) read them directly when busy=0.
- done and busy are registered outputs; no combinational path exists from the inputs to any output.
- Reserved op with start: ignored; state stays IDLE.

Decomposition:
- Shared package mdu_pkg:
  - op encodings MDU_MULT..MDU_MTLO
  - state encoding
  - DIV_ITER = 32
- Sub-module mdu_div_core: the iterative restoring divider on unsigned magnitudes, with load/step/result interface. Sign handling and the multiply path stay in mdu_hilo.

Test Plan:
- MULT a=0xFFFFFFFF b=2 -> busy high 4 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFE, done 1 cycle. MULTU with the same operands -> hi=0x00000001, lo=0xFFFFFFFE.
- DIV a=0xFFFFFFF9 (-7) b=2 -> busy 33 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=100 b=7 -> lo=14, hi=2.
- DIV a=0x80000000 b=0xFFFFFFFF -> lo=0x80000000, hi=0. DIVU a=0x1234 b=0 -> lo=0xFFFFFFFF, hi=0x1234 after 33 cycles.
- MTHI a=0xDEADBEEF, next cycle MTLO a=0x0BADF00D -> hi/lo updated on each edge, busy and done never assert.
- Start DIVU mid-busy (cycle 10 of a MULT with MULT_CYCLES=16) -> ignored; final hi/lo equal the MULT result only.
- Assert rst at cycle 15 of a DIV -> hi=lo=0 and busy=0 immediately (async); no done afterwards; a subsequent MULTU 3×5 gives lo=15, hi=0.
